hash_rom_lookup_sched: RTL and testbench



---
 rtl/hash_rom_lookup_pkg.sv | 16 +
 rtl/lookup_rsp_fifo.sv | 67 ++++++
 rtl/hash_rom_lookup_sched.sv | 190 +++++++++++++++++++
 tb/tb_hash_rom_lookup_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_rom_lookup_pkg.sv
// Shared types and constants for the hash-table ROM lookup scheduler.
// Optional statistics counters are enabled with LOOKUP_SCHED_STATS_EN.
package hash_rom_lookup_pkg;

  localparam int RSP_DEPTH   = 2;
  localparam int ROM_LATENCY = 1;
  localparam int IDX_W       = 3;
  localparam int MAX_TAG_W   = 32;

  typedef struct packed {
    logic                 vld;
    logic [IDX_W-1:0]     req_idx;
    logic [MAX_TAG_W-1:0] tag;
  } issue_slot_t;

endpackage

// File: rtl/lookup_rsp_fifo.sv
// Two-entry response buffer holding {data, tag} for one requester.
// Exposes occupancy so the scheduler can meter issue credits.
module lookup_rsp_fifo
  import hash_rom_lookup_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DWIDTH-1:0]    wr_data,
  input  logic [TAG_WIDTH-1:0] wr_tag,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [DWIDTH-1:0]    rd_data,
  output logic [TAG_WIDTH-1:0] rd_tag,
  output logic [1:0]           occ
);

  localparam int EW = DWIDTH + TAG_WIDTH;

  logic [EW-1:0] mem_q [RSP_DEPTH];
  logic [EW-1:0] mem_d [RSP_DEPTH];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    occ_q, occ_d;
  logic          pop;
  logic [EW-1:0] head;

  assign pop = rd_ready && (occ_q != 2'd0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = {wr_data, wr_tag};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_q + 2'(wr_en) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Zero the outputs when empty so stale entries never leak.
  assign rd_valid          = occ_q != 2'd0;
  assign head              = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign {rd_data, rd_tag} = head;
  assign occ               = occ_q;

endmodule

// File: rtl/hash_rom_lookup_sched.sv
// Round-robin scheduler sharing a dual-port hash ROM among requesters.
// Define LOOKUP_SCHED_STATS_EN to add lookup/stall counters.
module hash_rom_lookup_sched
  import hash_rom_lookup_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int AWIDTH    = 15,
  parameter int DWIDTH    = 16,
  parameter int TAG_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*AWIDTH-1:0]      req_addr,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [NUM_REQ*DWIDTH-1:0]      rsp_data,
  output logic [NUM_REQ*TAG_WIDTH-1:0]   rsp_tag,
  output logic [AWIDTH-1:0]              rom_address_a,
  output logic [AWIDTH-1:0]              rom_address_b,
  input  logic [DWIDTH-1:0]              rom_q_a,
  input  logic [DWIDTH-1:0]              rom_q_b
`ifdef LOOKUP_SCHED_STATS_EN
  ,
  output logic [31:0]                    stat_lookups,
  output logic [31:0]                    stat_stalls
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(RSP_DEPTH + ROM_LATENCY + 1);

  issue_slot_t        slot_a_q, slot_a_d;
  issue_slot_t        slot_b_q, slot_b_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] inflight;
  logic [NUM_REQ-1:0] wr_sel_a, wr_sel_b;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0]         occ [NUM_REQ];
  logic               gnt_a_vld, gnt_b_vld;
  logic [PW-1:0]      gnt_a_idx, gnt_b_idx;
  logic [PW-1:0]      ja;
  int                 j;
  logic               unused_tag_bits;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] idx);
    return (idx == PW'(NUM_REQ - 1)) ? '0 : idx + PW'(1);
  endfunction

  // A requester owns the write slot the cycle after it was granted.
  always_comb begin
    wr_sel_a = '0;
    wr_sel_b = '0;
    inflight = '0;
    elig     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_sel_a[i] = slot_a_q.vld && (slot_a_q.req_idx == IDX_W'(i));
      wr_sel_b[i] = slot_b_q.vld && (slot_b_q.req_idx == IDX_W'(i));
      inflight[i] = wr_sel_a[i] || wr_sel_b[i];
      elig[i]     = req_valid[i] &&
                    ((CW'(occ[i]) + CW'(inflight[i])) < CW'(RSP_DEPTH));
    end
  end

  always_comb begin
    gnt_a_vld = 1'b0;
    gnt_a_idx = '0;
    gnt_b_vld = 1'b0;
    gnt_b_idx = '0;
    j         = 0;
    ja        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      ja = PW'(j);
      if (!gnt_a_vld && elig[ja]) begin
        gnt_a_vld = 1'b1;
        gnt_a_idx = ja;
      end
    end
    for (int k = 1; k < NUM_REQ; k++) begin
      j = int'(gnt_a_idx) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      ja = PW'(j);
      if (gnt_a_vld && !gnt_b_vld && elig[ja]) begin
        gnt_b_vld = 1'b1;
        gnt_b_idx = ja;
      end
    end
    if (rst) begin
      gnt_a_vld = 1'b0;
      gnt_b_vld = 1'b0;
    end
  end

  always_comb begin
    gnt           = '0;
    rom_address_a = '0;
    rom_address_b = '0;
    slot_a_d      = '0;
    slot_b_d      = '0;
    slot_a_d.vld  = gnt_a_vld;
    slot_b_d.vld  = gnt_b_vld;
    slot_a_d.req_idx = IDX_W'(gnt_a_idx);
    slot_b_d.req_idx = IDX_W'(gnt_b_idx);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_a_vld && (gnt_a_idx == PW'(i))) begin
        gnt[i]        = 1'b1;
        rom_address_a = req_addr[i*AWIDTH +: AWIDTH];
        slot_a_d.tag[TAG_WIDTH-1:0] = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
      if (gnt_b_vld && (gnt_b_idx == PW'(i))) begin
        gnt[i]        = 1'b1;
        rom_address_b = req_addr[i*AWIDTH +: AWIDTH];
        slot_b_d.tag[TAG_WIDTH-1:0] = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (gnt_b_vld)      rr_ptr_d = nxt(gnt_b_idx);
    else if (gnt_a_vld) rr_ptr_d = nxt(gnt_a_idx);
  end

  assign req_ready = gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_a_q <= '0;
      slot_b_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      slot_a_q <= slot_a_d;
      slot_b_q <= slot_b_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign unused_tag_bits = ^{slot_a_q.tag, slot_b_q.tag};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    logic [DWIDTH-1:0]    wd, fd;
    logic [TAG_WIDTH-1:0] wt, ft;
    assign wd = wr_sel_a[i] ? rom_q_a : rom_q_b;
    assign wt = wr_sel_a[i] ? slot_a_q.tag[TAG_WIDTH-1:0]
                            : slot_b_q.tag[TAG_WIDTH-1:0];
    lookup_rsp_fifo #(
      .DWIDTH   (DWIDTH),
      .TAG_WIDTH(TAG_WIDTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (inflight[i]),
      .wr_data (wd),
      .wr_tag  (wt),
      .rd_ready(rsp_ready[i]),
      .rd_valid(rsp_valid[i]),
      .rd_data (fd),
      .rd_tag  (ft),
      .occ     (occ[i])
    );
    assign rsp_data[i*DWIDTH +: DWIDTH]       = fd;
    assign rsp_tag[i*TAG_WIDTH +: TAG_WIDTH]  = ft;
  end

`ifdef LOOKUP_SCHED_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;

  always_comb begin
    stat_lookups_d = stat_lookups_q + 32'(gnt_a_vld) + 32'(gnt_b_vld);
    stat_stalls_d  = stat_stalls_q + 32'(|(req_valid & ~gnt));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups_q <= '0;
      stat_stalls_q  <= '0;
    end else begin
      stat_lookups_q <= stat_lookups_d;
      stat_stalls_q  <= stat_stalls_d;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_stalls  = stat_stalls_q;
`endif

endmodule

// File: tb/tb_hash_rom_lookup_sched.sv
// Scoreboard bench for hash_rom_lookup_sched with a behavioural ROM.
// Stats checks are included when LOOKUP_SCHED_STATS_EN is defined.
module tb_hash_rom_lookup_sched;

  localparam int NR = 4;
  localparam int AW = 15;
  localparam int DW = 16;
  localparam int TW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*TW-1:0] req_tag;
  logic [NR-1:0]    rsp_valid, rsp_ready;
  logic [NR*DW-1:0] rsp_data;
  logic [NR*TW-1:0] rsp_tag;
  logic [AW-1:0]    rom_address_a, rom_address_b;
  logic [DW-1:0]    rom_q_a = '0, rom_q_b = '0;
`ifdef LOOKUP_SCHED_STATS_EN
  logic [31:0]      stat_lookups, stat_stalls;
`endif

  logic [AW-1:0] addr [NR];
  logic [TW-1:0] tag  [NR];
  logic [DW+TW-1:0] sb [NR][$];
  int n_chk = 0;
  int n_fail = 0;
  int hs, hs2;

  always #5 clk = ~clk;

  hash_rom_lookup_sched #(
    .NUM_REQ(NR), .AWIDTH(AW), .DWIDTH(DW), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rom_address_a(rom_address_a), .rom_address_b(rom_address_b),
    .rom_q_a(rom_q_a), .rom_q_b(rom_q_b)
`ifdef LOOKUP_SCHED_STATS_EN
    , .stat_lookups(stat_lookups), .stat_stalls(stat_stalls)
`endif
  );

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return 16'(16'(a) * 16'd40503 + 16'd1);
  endfunction

  always @(posedge clk) begin
    rom_q_a <= rom_f(rom_address_a);
    rom_q_b <= rom_f(rom_address_b);
  end

  always_comb begin
    req_addr = '0;
    req_tag  = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = addr[i];
      req_tag[i*TW +: TW]  = tag[i];
    end
  end

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops on each response handshake, pushes on each request one.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) sb[i].delete();
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (sb[i].size() == 0) begin
            check($sformatf("unexpected_rsp%0d", i), 64'(rsp_valid[i]), 64'd0);
          end else begin
            check($sformatf("rsp%0d", i),
                  64'({rsp_data[i*DW +: DW], rsp_tag[i*TW +: TW]}),
                  64'(sb[i].pop_front()));
          end
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i])
          sb[i].push_back({rom_f(addr[i]), tag[i]});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    req_valid = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic drain();
    cyc();
    req_valid = '0;
    rsp_ready = '1;
    repeat (4) cyc();
    check("drain_empty",
          64'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = '1;
    for (int i = 0; i < NR; i++) begin
      addr[i] = AW'(16'h0100 + i);
      tag[i]  = TW'(i);
    end
    repeat (3) cyc();
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rom_a", 64'(rom_address_a), 64'd0);
    check("rst_rom_b", 64'(rom_address_b), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_tag", 64'(rsp_tag), 64'd0);

    // Single request from requester 0.
    cyc();
    rst = 1'b0;
    req_valid = 4'b0001;
    addr[0] = 15'h0005;
    tag[0] = 8'h11;
    #1;
    check("single_ready", 64'(req_ready), 64'h1);
    check("single_rom_a", 64'(rom_address_a), 64'h5);
    check("single_rom_b", 64'(rom_address_b), 64'h0);
    cyc();
    req_valid = '0;
    #1;
    check("single_lat1", 64'(rsp_valid), 64'h0);
    cyc();
    #1;
    check("single_lat2", 64'(rsp_valid), 64'h1);
    check("single_data", 64'(rsp_data[15:0]), 64'h1714);
    check("single_tag", 64'(rsp_tag[7:0]), 64'h11);
    drain();

    // All four requesters continuously valid.
    do_reset();
    for (int k = 0; k < 500; k++) begin
      cyc();
      req_valid = '1;
      for (int i = 0; i < NR; i++) begin
        addr[i] = AW'($urandom);
        tag[i]  = TW'($urandom);
      end
      #1;
      check("rr_pattern", 64'(req_ready), (k % 2 == 0) ? 64'h3 : 64'hC);
    end
    drain();

    // Backpressure on requester 2.
    hs = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      rsp_ready = 4'b1011;
      req_valid = 4'b0100;
      addr[2] = AW'(100 + hs);
      tag[2]  = TW'(32'h20 + hs);
      #1;
      if (req_ready[2]) hs++;
    end
    check("bp_handshakes", 64'(hs), 64'd2);
    check("bp_ready_low", 64'(req_ready[2]), 64'd0);
    check("bp_rsp_valid", 64'(rsp_valid[2]), 64'd1);
    check("bp_rsp_tag", 64'(rsp_tag[23:16]), 64'h20);
    check("bp_rsp_data", 64'(rsp_data[47:32]), 64'hCD7D);
    hs2 = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      rsp_ready = '1;
      addr[2] = AW'(100 + hs + hs2);
      tag[2]  = TW'(32'h20 + hs + hs2);
      #1;
      if (req_ready[2]) hs2++;
    end
    check("bp_resume", 64'(hs2 != 0), 64'd1);
    drain();

    // Only requester 3 valid with the pointer at 0.
    do_reset();
    cyc();
    req_valid = 4'b1000;
    addr[3] = 15'h0ABC;
    tag[3] = 8'h33;
    #1;
    check("r3_ready", 64'(req_ready), 64'h8);
    check("r3_rom_a", 64'(rom_address_a), 64'hABC);
    check("r3_rom_b", 64'(rom_address_b), 64'h0);
    cyc();
    req_valid = 4'b1111;
    addr[0] = 15'h0123;
    #1;
    check("r3_ptr_wrap", 64'(req_ready), 64'h3);
    check("r3_next_rom_a", 64'(rom_address_a), 64'h123);
    drain();

    // Reset with lookups in flight and buffers occupied.
    for (int k = 0; k < 3; k++) begin
      cyc();
      rsp_ready = '0;
      req_valid = '1;
    end
    cyc();
    req_valid = '0;
    #1;
    check("mid_buf_full", 64'(|rsp_valid), 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rsp_ready = '1;
    #1;
    check("mid_rst_clear", 64'(rsp_valid), 64'd0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      #1;
      check("mid_no_stale", 64'(rsp_valid), 64'd0);
    end

`ifdef LOOKUP_SCHED_STATS_EN
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc();
      rsp_ready = '1;
      req_valid = 4'b0111;
    end
    cyc();
    req_valid = '0;
    #1;
    check("stat_lookups", 64'(stat_lookups), 64'd20);
    check("stat_stalls", 64'(stat_stalls), 64'd10);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
